// File: rtl/gpio_hex_display.sv
// Decimal display driver for the CPU GPIO_out word: serial double-dabble into eight active-low 7-segment digits.
// Optional GPIO_HEX_LZ_BLANK_EN blanks leading-zero digits on HEX7..HEX1.
module gpio_hex_display #(
    parameter int SHIFT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value_in,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [4:0] CNT_LAST  = 5'(SHIFT_CYCLES - 1);

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     last_q, last_d;
    logic [31:0]     bin_q, bin_d;
    logic [39:0]     bcd_q, bcd_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic [7:0][6:0] hex_q, hex_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [39:0]     adj;
`ifdef GPIO_HEX_LZ_BLANK_EN
    logic            lead;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b1;
            hex_q     <= {8{SEG_BLANK}};
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        hex_d     = hex_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        adj       = bcd_q;
`ifdef GPIO_HEX_LZ_BLANK_EN
        lead      = 1'b1;
`endif
        // Add-3 per digit, no carry between digits.
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if ((value_in != last_q) || pending_q) begin
                    last_d    = value_in;
                    bin_d     = value_in;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = (adj << 1) | {39'd0, bin_q[31]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) state_d = UPDATE;
            end
            UPDATE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (bcd_q[39:32] != 8'd0) begin
                    hex_d = {8{SEG_DASH}};
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = 1'b0;
                    for (int i = 0; i < 8; i++) hex_d[i] = seg_of(bcd_q[4*i +: 4]);
`ifdef GPIO_HEX_LZ_BLANK_EN
                    // Walk down from the top; HEX0 is never blanked.
                    for (int i = 7; i >= 1; i--) begin
                        if (lead && (bcd_q[4*i +: 4] == 4'd0)) hex_d[i] = SEG_BLANK;
                        else lead = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;
    assign HEX0        = hex_q[0];
    assign HEX1        = hex_q[1];
    assign HEX2        = hex_q[2];
    assign HEX3        = hex_q[3];
    assign HEX4        = hex_q[4];
    assign HEX5        = hex_q[5];
    assign HEX6        = hex_q[6];
    assign HEX7        = hex_q[7];

endmodule

// File: tb/tb_gpio_hex_display.sv
// Scoreboard bench for gpio_hex_display: decimal reference model, expected queue, done-driven monitor.
module tb_gpio_hex_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value_in = '0;
    logic        busy, done, ovf;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    logic [56:0] exp_q[$];
    logic [31:0] last_sent = '0;
    logic        done_prev = 1'b0;

    wire [55:0] hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    gpio_hex_display dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5),
        .HEX6        (HEX6),
        .HEX7        (HEX7),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_tab(input int d);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tab[d];
    endfunction

    // Returns {ovf, HEX7..HEX0} for a converted value.
    function automatic logic [56:0] model(input logic [31:0] v);
        logic [55:0] hex;
        longint unsigned n;
        int nd;
        if (v >= 32'd100_000_000) return {1'b1, {8{7'h3F}}};
        n = v;
        for (int i = 0; i < 8; i++) begin
            hex[i*7 +: 7] = seg_tab(int'(n % 10));
            n = n / 10;
        end
        nd = 1;
        n = v;
        while (n >= 10) begin
            n = n / 10;
            nd++;
        end
`ifdef GPIO_HEX_LZ_BLANK_EN
        for (int i = 1; i < 8; i++) if (i >= nd) hex[i*7 +: 7] = 7'h7F;
`endif
        return {1'b0, hex};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("done_pulse", {63'd0, done_prev}, 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got display %h required no done", hex_all);
            end else begin
                logic [56:0] e;
                e = exp_q.pop_front();
                check("display", {7'd0, ovf, hex_all}, {7'd0, e});
            end
        end
        done_prev <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 200);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in %0d cycles required done", lat);
        end
    endtask

    // Called at a negedge with the DUT idle; start edge is the next posedge.
    task automatic convert(input logic [31:0] v);
        int lat, bc;
        value_in = v;
        last_sent = v;
        exp_q.push_back(model(v));
        wait_done(lat, bc);
        check("latency", 64'(lat), 64'd34);
        check("busy_cycles", 64'(bc), 64'd33);
        check("busy_low_at_done", {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] fresh(input logic [31:0] v);
        return (v == last_sent) ? (v ^ 32'd1) : v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int lat, bc;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        check("reset_hex", {8'd0, hex_all}, {8'd0, {8{7'h7F}}});
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_ovf", {63'd0, ovf}, 64'd0);

        // First conversion runs unconditionally after reset release.
        rst_n = 1'b1;
        exp_q.push_back(model(32'd0));
        wait_done(lat, bc);
        check("reset_latency", 64'(lat), 64'd34);
        check("reset_busy_cycles", 64'(bc), 64'd33);

        convert(32'd4);
        convert(32'd12_345_678);
        convert(32'd100_000_000);
        convert(32'hFFFF_FFFF);
        convert(32'd9);
        convert(32'd99_999_999);
        convert(32'd10);

        // Input change mid-conversion is picked up right after the first done.
        value_in = 32'd5;
        exp_q.push_back(model(32'd5));
        repeat (10) @(negedge clk);
        value_in = 32'd7;
        last_sent = 32'd7;
        exp_q.push_back(model(32'd7));
        wait_done(lat, bc);
        wait_done(lat, bc);
        check("second_conv_latency", 64'(lat), 64'd34);

        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       v = 32'($urandom_range(0, 999));
                1:       v = 32'($urandom_range(0, 99_999_999));
                default: v = $urandom;
            endcase
            convert(fresh(v));
        end

        // Asynchronous reset in the middle of a conversion.
        v = fresh($urandom_range(1, 99_999_999));
        value_in = v;
        last_sent = v;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hex", {8'd0, hex_all}, {8'd0, {8{7'h7F}}});
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(v));
        wait_done(lat, bc);
        check("midrst_latency", 64'(lat), 64'd34);

        convert(fresh(32'd0));

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
